// File: rtl/addsub_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial_pkg
// Description : Opcodes, status flag positions and FSM states for addsub_serial.
// Revision    : 1.0
// ============================================================================
package addsub_serial_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : SLICE-bit ripple adder reporting carry out and carry into MSB.
// Revision    : 1.0
// ============================================================================
module addsub_slice #(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [SLICE:0] w_total;

  assign w_total = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
  assign sum     = w_total[SLICE-1:0];
  assign cout    = w_total[SLICE];
  // MSB sum bit is a^b^carry_in, so the carry into it falls out by XOR.
  assign cmsb    = w_total[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : addsub_serial
// Description : Slice-serial add/subtract with NZCV flags and valid/ready I/O.
// Revision    : 1.0
// ============================================================================
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic [1:0]       opMode,
  input  logic             carryIn,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       statusOut,
  output logic             outValid,
  input  logic             outReady
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(NSLICE - 1);

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_result;
  logic [3:0]         r_status;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_carry;

  logic               w_is_sub;
  logic               w_cin0;
  logic               w_last;
  logic [SLICE-1:0]   w_sum;
  logic               w_cout;
  logic               w_cmsb;
  logic [WIDTH+SLICE-1:0] w_cat;
  logic [WIDTH-1:0]   w_res_next;
  logic [3:0]         w_status;

  addsub_slice #(.SLICE(SLICE)) u_slice (
    .a    (r_a[SLICE-1:0]),
    .b    (r_b[SLICE-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout),
    .cmsb (w_cmsb)
  );

  assign w_is_sub   = (opMode == OP_SUB) || (opMode == OP_SBC);
  assign w_cin0     = (opMode == OP_ADD) ? 1'b0 : (opMode == OP_SUB) ? 1'b1 : carryIn;
  assign w_last     = (r_cnt == c_last);
  // New slice enters at the top; after NSLICE shifts the LSB slice sits at bit 0.
  assign w_cat      = {w_sum, r_result};
  assign w_res_next = w_cat[WIDTH+SLICE-1:SLICE];

  always_comb begin
    w_status         = 4'b0000;
    w_status[FLAG_N] = w_res_next[WIDTH-1];
    w_status[FLAG_Z] = (w_res_next == '0);
    w_status[FLAG_C] = w_cout;
    w_status[FLAG_V] = w_cmsb ^ w_cout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (inValid)  w_next = ST_BUSY;
      ST_BUSY: if (w_last)   w_next = ST_DONE;
      ST_DONE: if (outReady) w_next = ST_IDLE;
      default:               w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_status <= 4'b0000;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (inValid) begin
            r_a     <= operand1;
            r_b     <= w_is_sub ? ~operand2 : operand2;
            r_carry <= w_cin0;
            r_cnt   <= '0;
          end
        end
        ST_BUSY: begin
          r_a      <= r_a >> SLICE;
          r_b      <= r_b >> SLICE;
          r_carry  <= w_cout;
          r_result <= w_res_next;
          if (w_last) begin
            r_cnt    <= '0;
            r_status <= w_status;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign inReady   = (r_state == ST_IDLE);
  assign outValid  = (r_state == ST_DONE);
  assign result    = r_result;
  assign statusOut = r_status;

endmodule
`default_nettype wire

// File: tb/tb_addsub_serial.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_serial
// Description : Directed and random scoreboard bench for addsub_serial (8/2).
// Revision    : 1.0
// ============================================================================
module tb_addsub_serial;

  localparam int WIDTH = 8;
  localparam int SLICE = 2;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] operand1;
  logic [WIDTH-1:0] operand2;
  logic [1:0]       opMode;
  logic             carryIn;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] result;
  logic [3:0]       statusOut;
  logic             outValid;
  logic             outReady;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] st;
  } exp_t;

  exp_t sb[$];

  addsub_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .operand1  (operand1),
    .operand2  (operand2),
    .opMode    (opMode),
    .carryIn   (carryIn),
    .inValid   (inValid),
    .inReady   (inReady),
    .result    (result),
    .statusOut (statusOut),
    .outValid  (outValid),
    .outReady  (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: whole-word arithmetic, overflow from operand signs.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] a,
                                 input logic [7:0] b, input logic cin);
    logic [7:0] bb;
    logic       c0;
    logic [8:0] s;
    exp_t       e;
    bb = op[0] ? ~b : b;
    c0 = (op == 2'b00) ? 1'b0 : (op == 2'b01) ? 1'b1 : cin;
    s  = {1'b0, a} + {1'b0, bb} + {8'd0, c0};
    e.res = s[7:0];
    e.st  = {s[7], (s[7:0] == 8'd0), s[8], (a[7] == bb[7]) && (s[7] != a[7])};
    return e;
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input exp_t e, input int hold);
    int   n;
    exp_t got;
    sb.push_back(e);
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", {31'd0, inReady}, 32'd1);
    opMode = op; operand1 = a; operand2 = b; carryIn = cin; inValid = 1'b1;
    @(negedge clk);
    inValid  = 1'b0;
    operand1 = 8'($urandom);
    operand2 = 8'($urandom);
    opMode   = 2'($urandom);
    carryIn  = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      chk("busy_outvalid", {31'd0, outValid}, 32'd0);
      chk("busy_inready", {31'd0, inReady}, 32'd0);
      inValid  = 1'($urandom);
      outReady = 1'($urandom);
      @(negedge clk);
    end
    inValid  = 1'b0;
    outReady = 1'b0;
    chk("latency_outvalid", {31'd0, outValid}, 32'd1);
    if (outValid && sb.size() > 0) begin
      got = sb.pop_front();
      chk("result", {24'd0, result}, {24'd0, got.res});
      chk("status", {28'd0, statusOut}, {28'd0, got.st});
      for (int h = 0; h < hold; h++) begin
        operand1 = 8'($urandom);
        operand2 = 8'($urandom);
        inValid  = 1'b1;
        @(negedge clk);
        chk("hold_result", {24'd0, result}, {24'd0, got.res});
        chk("hold_status", {28'd0, statusOut}, {28'd0, got.st});
        chk("hold_inready", {31'd0, inReady}, 32'd0);
        chk("hold_outvalid", {31'd0, outValid}, 32'd1);
      end
    end
    // inValid stays high across the leaving edge; it must not start a new op.
    inValid  = 1'b1;
    outReady = 1'b1;
    @(negedge clk);
    inValid  = 1'b0;
    outReady = 1'b0;
    chk("leave_outvalid", {31'd0, outValid}, 32'd0);
    chk("leave_inready", {31'd0, inReady}, 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;

    rst_n = 1'b0; operand1 = '0; operand2 = '0; opMode = '0;
    carryIn = 1'b0; inValid = 1'b0; outReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_inready", {31'd0, inReady}, 32'd1);
    chk("rst_outvalid", {31'd0, outValid}, 32'd0);
    chk("rst_result", {24'd0, result}, 32'd0);
    chk("rst_status", {28'd0, statusOut}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(2'b00, 8'h7F, 8'h01, 1'b0, '{res: 8'h80, st: 4'b1001}, 0);
    run_op(2'b01, 8'h05, 8'h05, 1'b0, '{res: 8'h00, st: 4'b0110}, 0);
    run_op(2'b01, 8'h00, 8'h01, 1'b0, '{res: 8'hFF, st: 4'b1000}, 0);
    run_op(2'b01, 8'h80, 8'h01, 1'b0, '{res: 8'h7F, st: 4'b0011}, 0);
    run_op(2'b00, 8'hFF, 8'h01, 1'b1, '{res: 8'h00, st: 4'b0110}, 0);
    run_op(2'b10, 8'hFE, 8'h01, 1'b1, '{res: 8'h00, st: 4'b0110}, 0);
    run_op(2'b11, 8'h10, 8'h01, 1'b0, '{res: 8'h0E, st: 4'b0010}, 0);
    run_op(2'b00, 8'h3C, 8'h5A, 1'b0, '{res: 8'h96, st: 4'b1001}, 5);

    for (int k = 0; k < 10; k++) begin
      op = 2'($urandom); a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      e  = model(op, a, b, c);
      run_op(op, a, b, c, e, k % 2);
    end

    // Abort an operation in its second BUSY cycle.
    opMode = 2'b00; operand1 = 8'h12; operand2 = 8'h34; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_outvalid", {31'd0, outValid}, 32'd0);
    chk("abort_inready", {31'd0, inReady}, 32'd1);
    chk("abort_result", {24'd0, result}, 32'd0);
    chk("abort_status", {28'd0, statusOut}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_output", {31'd0, outValid}, 32'd0);
    end

    run_op(2'b01, 8'h20, 8'h30, 1'b0, '{res: 8'hF0, st: 4'b1000}, 0);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
